// File: rtl/dcache_responder.sv
// dcache_responder
//   Memory-side responder for the load/store unit's data cache bus.
//   Direct-mapped, one 32-bit word per line, write-through and
//   no-write-allocate. One request is handled at a time. Load misses
//   and every store go to the backing memory over a req/ack handshake.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   flush                 invalidate all lines (honoured in IDLE only)
//   req_*                 request from the load/store unit (valid/ready)
//   resp_valid/resp_rdata one-cycle response; rdata is 0 for stores
//   mem_*                 backing-memory port, mem_req held until mem_ack
//
// Optional build macro
//   DCACHE_STATS_EN       adds hit_count / miss_count outputs (loads only,
//                         saturating, cleared by reset, kept across flush)

module dcache_responder #(
    parameter int SETS   = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int IDX_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESP} state_t;

    state_t              state_q;
    logic [ADDR_W-3:0]   waddr_q;      // latched word address
    logic                we_q;
    logic [31:0]         wdata_q;
    logic [3:0]          be_q;

    logic [SETS-1:0]     valid_q;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [31:0]         data_q [SETS];

    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [3:0]          mem_be_q;

`ifdef DCACHE_STATS_EN
    logic [31:0]         hit_q;
    logic [31:0]         miss_q;
`endif

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                hit;
    logic [31:0]         line_d;       // line data with store bytes merged

    // Byte offset bits never reach the cache or memory.
    logic                unused_addr_lsb;
    assign unused_addr_lsb = ^req_address[1:0];

    assign idx = waddr_q[IDX_W-1:0];
    assign tag = waddr_q[ADDR_W-3 -: TAG_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        line_d = data_q[idx];
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) line_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // Ready is gated by flush so a request presented alongside a flush is
    // never handshaken, and by reset so it reads low while reset is held.
    assign req_ready   = reset && (state_q == IDLE) && !flush;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
`ifdef DCACHE_STATS_EN
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            waddr_q      <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
`ifdef DCACHE_STATS_EN
            hit_q        <= '0;
            miss_q       <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        waddr_q <= req_address[ADDR_W-1:2];
                        we_q    <= req_we;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    mem_addr_q <= {waddr_q, 2'b00};
                    if (!we_q) begin
                        if (hit) begin
                            resp_rdata_q <= data_q[idx];
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
`ifdef DCACHE_STATS_EN
                            if (hit_q != 32'hFFFF_FFFF) hit_q <= hit_q + 32'd1;
`endif
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            state_q   <= FILL;
`ifdef DCACHE_STATS_EN
                            if (miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
`endif
                        end
                    end else begin
                        // Write-through: every store goes out; only a hit
                        // touches the line (no allocate on miss).
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= wdata_q;
                        mem_be_q    <= be_q;
                        if (hit) data_q[idx] <= line_d;
                        state_q     <= WRITE;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid_q[idx] <= 1'b1;
                        tag_q[idx]   <= tag;
                        data_q[idx]  <= mem_rdata;
                        mem_req_q    <= 1'b0;
                        resp_rdata_q <= mem_rdata;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req_q    <= 1'b0;
                        mem_we_q     <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed testbench for dcache_responder (SETS = 16, ADDR_W = 32).
// Inputs change on the falling edge or #1 after the rising edge; outputs
// are sampled on the falling edge. Cycle k counts from the acceptance edge.

module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_we;
    logic [31:0] req_address, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dcache_responder #(.SETS(16), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_we(req_we), .req_address(req_address),
        .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Result of one transaction
    int          r_lat, r_reqcyc;
    logic        r_we, r_post_rdy, r_post_rv, r_rdy0;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;

    // Issue one request starting at a falling edge; memory acks on the
    // n_ack-th cycle of mem_req. Returns at the falling edge after RESP.
    task automatic xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int n_ack, input logic [31:0] mrdata);
        r_lat = -1; r_reqcyc = 0; r_we = 1'b0; r_addr = '0;
        r_wdata = '0; r_be = '0; r_rdata = '0;
        req_valid = 1'b1; req_we = we; req_address = addr;
        req_wdata = wdata; req_be = be;
        #1 r_rdy0 = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req) begin
                r_reqcyc++;
                if (r_reqcyc == 1) begin
                    r_we = mem_we; r_addr = mem_address;
                    r_wdata = mem_wdata; r_be = mem_be;
                end
                if (r_reqcyc == n_ack) begin
                    mem_ack = 1'b1; mem_rdata = mrdata;
                end
            end
            if (resp_valid) begin
                r_lat = k; r_rdata = resp_rdata;
                break;
            end
        end
        mem_ack = 1'b0;
        @(negedge clk);
        r_post_rdy = req_ready;
        r_post_rv  = resp_valid;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp: got %b/%h want 0/0", resp_valid, resp_rdata); end
        n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'h0 || mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_mem: got req=%b we=%b be=%h a=%h d=%h want all 0", mem_req, mem_we, mem_be, mem_address, mem_wdata); end
`ifdef DCACHE_STATS_EN
        n_cmp++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", hit_count, miss_count); end
`endif
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_load_miss_hit;
        xact(1'b0, 32'h40, 32'h0, 4'h0, 3, 32'hDEADBEEF);
        n_cmp++; if (r_rdy0 !== 1'b1) begin n_bad++; $display("FAIL miss_ready: got %b want 1", r_rdy0); end
        n_cmp++; if (r_reqcyc != 3) begin n_bad++; $display("FAIL miss_reqcyc: got %0d want 3", r_reqcyc); end
        n_cmp++; if (r_addr !== 32'h40 || r_we !== 1'b0) begin n_bad++; $display("FAIL miss_mem: got a=%h we=%b want 40/0", r_addr, r_we); end
        n_cmp++; if (r_lat != 5) begin n_bad++; $display("FAIL miss_lat: got %0d want 5", r_lat); end
        n_cmp++; if (r_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL miss_rdata: got %h want deadbeef", r_rdata); end
        n_cmp++; if (r_post_rv !== 1'b0 || r_post_rdy !== 1'b1) begin n_bad++; $display("FAIL miss_pulse: got rv=%b rdy=%b want 0/1", r_post_rv, r_post_rdy); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0);
        n_cmp++; if (r_reqcyc != 0) begin n_bad++; $display("FAIL hit_reqcyc: got %0d want 0", r_reqcyc); end
        n_cmp++; if (r_lat != 2) begin n_bad++; $display("FAIL hit_lat: got %0d want 2", r_lat); end
        n_cmp++; if (r_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL hit_rdata: got %h want deadbeef", r_rdata); end
    endtask

    task automatic test_store_hit;
        // low address bits set: must be dropped on the memory side
        xact(1'b1, 32'h42, 32'h11223344, 4'b0011, 2, 32'h0);
        n_cmp++; if (r_we !== 1'b1 || r_be !== 4'b0011) begin n_bad++; $display("FAIL st_we_be: got %b/%b want 1/0011", r_we, r_be); end
        n_cmp++; if (r_addr !== 32'h40 || r_wdata !== 32'h11223344) begin n_bad++; $display("FAIL st_addr_data: got %h/%h want 40/11223344", r_addr, r_wdata); end
        n_cmp++; if (r_lat != 4 || r_rdata !== 32'h0) begin n_bad++; $display("FAIL st_resp: got lat=%0d rd=%h want 4/0", r_lat, r_rdata); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0);
        n_cmp++; if (r_lat != 2 || r_reqcyc != 0) begin n_bad++; $display("FAIL st_hit_lat: got %0d/%0d want 2/0", r_lat, r_reqcyc); end
        n_cmp++; if (r_rdata !== 32'hDEAD3344) begin n_bad++; $display("FAIL st_merge: got %h want dead3344", r_rdata); end
    endtask

    task automatic test_store_miss;
        xact(1'b1, 32'h80, 32'hAABBCCDD, 4'hF, 1, 32'h0);
        n_cmp++; if (r_we !== 1'b1 || r_lat != 3) begin n_bad++; $display("FAIL stm_write: got we=%b lat=%0d want 1/3", r_we, r_lat); end
        xact(1'b0, 32'h80, 32'h0, 4'h0, 1, 32'h12345678);
        n_cmp++; if (r_reqcyc != 1 || r_we !== 1'b0) begin n_bad++; $display("FAIL stm_load_miss: got reqcyc=%0d we=%b want 1/0", r_reqcyc, r_we); end
        n_cmp++; if (r_rdata !== 32'h12345678 || r_lat != 3) begin n_bad++; $display("FAIL stm_load_data: got %h lat=%0d want 12345678/3", r_rdata, r_lat); end
    endtask

    task automatic test_tag_conflict;
        xact(1'b0, 32'h440, 32'h0, 4'h0, 2, 32'hCAFEF00D);
        n_cmp++; if (r_reqcyc != 2 || r_addr !== 32'h440) begin n_bad++; $display("FAIL tc_miss: got reqcyc=%0d a=%h want 2/440", r_reqcyc, r_addr); end
        n_cmp++; if (r_rdata !== 32'hCAFEF00D || r_lat != 4) begin n_bad++; $display("FAIL tc_data: got %h lat=%0d want cafef00d/4", r_rdata, r_lat); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0BADF00D);
        n_cmp++; if (r_reqcyc != 1 || r_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL tc_reload: got reqcyc=%0d rd=%h want 1/0badf00d", r_reqcyc, r_rdata); end
    endtask

    task automatic test_be_zero;
        xact(1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, 1, 32'h0);
        n_cmp++; if (r_reqcyc != 1 || r_be !== 4'h0 || r_we !== 1'b1) begin n_bad++; $display("FAIL be0_write: got reqcyc=%0d be=%h we=%b want 1/0/1", r_reqcyc, r_be, r_we); end
        n_cmp++; if (r_lat != 3) begin n_bad++; $display("FAIL be0_resp: got lat=%0d want 3", r_lat); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0);
        n_cmp++; if (r_lat != 2 || r_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL be0_line: got lat=%0d rd=%h want 2/0badf00d", r_lat, r_rdata); end
    endtask

    task automatic test_flush;
        flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_address = 32'h40;
        #1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
        @(posedge clk);
        #1 flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_idle: got rdy=%b req=%b want 1/0", req_ready, mem_req); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_noacc: got rv=%b req=%b want 0/0", resp_valid, mem_req); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h55AA55AA);
        n_cmp++; if (r_reqcyc != 1 || r_rdata !== 32'h55AA55AA) begin n_bad++; $display("FAIL flush_miss: got reqcyc=%0d rd=%h want 1/55aa55aa", r_reqcyc, r_rdata); end
    endtask

    task automatic test_reset_in_fill;
        req_valid = 1'b1; req_we = 1'b0; req_address = 32'h100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rif_inflight: got %b want 1", mem_req); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_req !== 1'b0 || req_ready !== 1'b0) begin n_bad++; $display("FAIL rif_during: got req=%b rdy=%b want 0/0", mem_req, req_ready); end
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h99999999;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rif_ready: got %b want 1", req_ready); end
        @(negedge clk);
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL rif_stray: got req=%b rv=%b rdy=%b want 0/0/1", mem_req, resp_valid, req_ready); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rif_noresp: got %b want 0", resp_valid); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h77777777);
        n_cmp++; if (r_reqcyc != 1 || r_rdata !== 32'h77777777) begin n_bad++; $display("FAIL rif_miss: got reqcyc=%0d rd=%h want 1/77777777", r_reqcyc, r_rdata); end
    endtask

    task automatic test_back_to_back;
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0);
        n_cmp++; if (r_rdy0 !== 1'b1 || r_lat != 2 || r_rdata !== 32'h77777777) begin
            n_bad++; $display("FAIL b2b_first: got rdy=%b lat=%0d rd=%h want 1/2/77777777", r_rdy0, r_lat, r_rdata); end
        xact(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'h0);
        n_cmp++; if (r_rdy0 !== 1'b1 || r_lat != 2 || r_rdata !== 32'h77777777) begin
            n_bad++; $display("FAIL b2b_second: got rdy=%b lat=%0d rd=%h want 1/2/77777777", r_rdy0, r_lat, r_rdata); end
`ifdef DCACHE_STATS_EN
        // since the last reset: one miss (0x40) then these two hits
        n_cmp++; if (miss_count !== 32'd1 || hit_count !== 32'd2) begin
            n_bad++; $display("FAIL stats: got hit=%0d miss=%0d want 2/1", hit_count, miss_count); end
`endif
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_address = '0; req_wdata = '0; req_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset;
        test_load_miss_hit;
        test_store_hit;
        test_store_miss;
        test_tag_conflict;
        test_be_zero;
        test_flush;
        test_reset_in_fill;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-side responder for the load/store unit's data cache bus: accepts one load or store at a time and returns read data or a write acknowledge.
- Direct-mapped, one 32-bit word per line, write-through, no-write-allocate data cache.
- Sits between the load/store execution unit (initiator) and the backing memory port.
- Misses and all stores go to memory over a req/ack handshake.

Parameters:
- SETS, 16, number of cache lines; power of two, 2..256.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  invalidate all lines; pulse, accepted only in IDLE
- req_valid  in  1  request present from load/store unit
- req_we  in  1  1 = store, 0 = load
- req_address  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_be  in  4  store byte enables; ignored for loads
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle pulse: load data valid or store complete
- resp_rdata  out  32  load data, valid with resp_valid; 0 for stores
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write
- mem_address  out  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  memory done; rdata valid same cycle for reads
- mem_rdata  in  32  memory read data

Behaviour:
- Address split: index = addr[2+log2(SETS)-1 : 2]; tag = remaining upper bits. Per line: valid, tag, data.
- Reset (reset == 0 at a clk edge), including mid-operation:
  - State goes to IDLE; all valid bits clear.
  - req_ready = 0 during reset, 1 on the first cycle after.
  - resp_valid = 0, resp_rdata = 0.
  - mem_req = 0, mem_we = 0, mem_address = 0, mem_wdata = 0, mem_be = 0.
  - Any in-flight memory transaction is abandoned; a later stray mem_ack is ignored.
- States: IDLE, LOOKUP, FILL, WRITE, RESP.
- IDLE: req_ready = 1.
  - flush: clear all valid bits in one cycle and stay in IDLE; req_ready = 0 that cycle.
  - flush takes priority over req_valid in the same cycle; that request is not accepted.
  - Otherwise an accepted request latches address, we, wdata and be, then goes to LOOKUP.
- LOOKUP (one cycle): hit = valid[index] & (tag match).
  - Load hit: go to RESP with the line data.
  - Load miss: mem_req = 1, mem_we = 0, go to FILL.
  - Store, hit or miss: mem_req = 1, mem_we = 1, mem_wdata/mem_be from the latched request, go to WRITE.
  - Store hit: merge enabled bytes into the line now; valid and tag unchanged.
  - Store miss: no line change.
- FILL: hold mem_req and mem_address until mem_ack.
  - On ack: write the line (valid = 1, tag, data = mem_rdata), drop mem_req, capture mem_rdata for the response, go to RESP.
- WRITE: hold until mem_ack, then drop mem_req/mem_we and go to RESP.
- RESP: resp_valid = 1 for exactly one cycle; resp_rdata = load data, or 0 for a store. Next state IDLE.
- Latency, counted from the acceptance edge to resp_valid high:
  - Load hit: 2 cycles.
  - Load miss or any store: 2 + N cycles, where N = cycles mem_req is high before mem_ack, N ≥ 1.
  - At most one request is outstanding; req_ready is low in every non-IDLE state.
- mem_ack outside FILL/WRITE is ignored.
- req_be == 0 on a store: memory write still issued with mem_be = 0; line unchanged; response still given.
- Back-to-back requests: the next request can be accepted on the cycle after RESP (IDLE).
- A load following a store to the same address returns the stored bytes, merged on hit; on a store miss the load misses and fetches from memory.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both cleared on reset.
  - Each increments by 1 in LOOKUP for loads only (hit or miss), saturating at 32'hFFFFFFFF.
  - flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040; memory acks after 3 cycles with 0xDEADBEEF:
  - mem_req high for 3 cycles, mem_address = 0x40.
  - resp_valid at cycle 5 with resp_rdata = 0xDEADBEEF.
  - Repeat load: resp_valid at cycle 2, no mem_req.
- Store 0x0000_0040, wdata = 0x11223344, be = 4'b0011, after the line above is filled:
  - mem_we = 1, mem_be = 4'b0011.
  - Following load hits and returns 0xDEAD3344.
- Store to uncached 0x0000_0080 (miss), then load 0x80:
  - Load misses; mem_req issued with mem_we = 0.
- Tag conflict: fill 0x0000_0040, then load 0x0000_0440 (same index with SETS = 16):
  - Second load misses; reload of 0x40 misses again.
- flush and req_valid high together in IDLE:
  - Request not accepted; next load of a previously cached address misses.
- Reset asserted while in FILL, then a stray mem_ack:
  - After reset mem_req = 0 and state IDLE; stray ack ignored.
  - Next load of the same address misses.
- (DCACHE_STATS_EN) 1 miss then 2 hits: miss_count = 1, hit_count = 2.
